// File: rtl/if_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Keeps one imem request in flight,
//               delivers fetched words into the IF/ID register and parks one
//               word in a skid buffer while decode is stalled. Taken branches
//               resolved against the IF/ID instruction redirect the fetch PC.
//               A request that is still in flight when a redirect happens is
//               allowed to complete, and its data is thrown away.
// Ports       : clk, reset_n             - clock, async active-low reset
//               imem_req/addr            - fetch request (held until ack)
//               imem_ack/rdata           - fetch response
//               stall                    - hold IF/ID (hazard unit)
//               br_taken/uncond/reg      - branch resolution controls
//               br_reg_val               - BR target register value
//               ifid_valid/instr/pc      - IF/ID pipeline register
//               link_pc                  - ifid_pc + 4 (BL link value)
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage #(
    parameter logic [63:0] RESET_PC  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        br_taken,
    input  logic        br_uncond,
    input  logic        br_reg,
    input  logic [63:0] br_reg_val,
    output logic        ifid_valid,
    output logic [31:0] ifid_instr,
    output logic [63:0] ifid_pc,
    output logic [63:0] link_pc
);

    localparam logic [1:0] c_st_idle = 2'd0;  // no request in flight
    localparam logic [1:0] c_st_wait = 2'd1;  // request in flight, data wanted
    localparam logic [1:0] c_st_drop = 2'd2;  // request in flight, data unwanted

    logic [1:0]  state_q,      state_d;
    logic [63:0] pc_q,         pc_d;
    logic [63:0] addr_q,       addr_d;
    logic        skid_valid_q, skid_valid_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [63:0] skid_pc_q,    skid_pc_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [63:0] ifid_pc_q,    ifid_pc_d;

    logic        w_redirect;
    logic        w_ack_wait;
    logic        w_issue;
    logic [63:0] w_off_uncond;
    logic [63:0] w_off_cond;
    logic [63:0] w_target;

    // A branch only counts when decode is actually consuming the instruction.
    assign w_redirect = br_taken & ifid_valid_q & ~stall;

    // Response that carries a word we intend to keep.
    assign w_ack_wait = (state_q == c_st_wait) & imem_ack;

    // A full skid buffer blocks new fetches, unless a redirect flushes it.
    assign w_issue = (state_q == c_st_idle) & (~skid_valid_q | w_redirect);

    // Sign-extended, word-scaled branch offsets from the IF/ID instruction.
    assign w_off_uncond = {{36{ifid_instr_q[25]}}, ifid_instr_q[25:0], 2'b00};
    assign w_off_cond   = {{43{ifid_instr_q[23]}}, ifid_instr_q[23:5], 2'b00};

    always_comb begin
        if (br_reg) begin
            w_target = br_reg_val & ~64'h3;
        end else if (br_uncond) begin
            w_target = ifid_pc_q + w_off_uncond;
        end else begin
            w_target = ifid_pc_q + w_off_cond;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= c_st_idle;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_st_idle: begin
                if (w_issue) begin
                    state_d = c_st_wait;
                end
            end
            c_st_wait: begin
                if (imem_ack) begin
                    state_d = c_st_idle;
                end else if (w_redirect) begin
                    state_d = c_st_drop;
                end
            end
            c_st_drop: begin
                if (imem_ack) begin
                    state_d = c_st_idle;
                end
            end
            default: state_d = c_st_idle;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        imem_req = (state_q == c_st_wait) || (state_q == c_st_drop);
    end

    // ------------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------------
    always_comb begin
        pc_d         = pc_q;
        addr_d       = addr_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        ifid_valid_d = ifid_valid_q;
        ifid_instr_d = ifid_instr_q;
        ifid_pc_d    = ifid_pc_q;

        // Fetch PC. A redirect coincident with an ack wins, so the
        // discarded word never advances the PC.
        if (w_redirect) begin
            pc_d = w_target;
        end else if (w_ack_wait) begin
            pc_d = pc_q + 64'd4;
        end

        // Request address is latched at issue and held until the ack.
        if (w_issue) begin
            addr_d = w_redirect ? w_target : pc_q;
        end

        if (w_redirect) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = NOP_INSTR;
            skid_valid_d = 1'b0;
            skid_instr_d = NOP_INSTR;
        end else if (!stall) begin
            if (skid_valid_q) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = skid_instr_q;
                ifid_pc_d    = skid_pc_q;
                skid_valid_d = 1'b0;
                skid_instr_d = NOP_INSTR;
            end else if (w_ack_wait) begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = imem_rdata;
                ifid_pc_d    = addr_q;
            end else begin
                // Decode consumed the previous instruction; show a bubble.
                ifid_valid_d = 1'b0;
                ifid_instr_d = NOP_INSTR;
            end
        end else if (w_ack_wait) begin
            if (ifid_valid_q) begin
                skid_valid_d = 1'b1;
                skid_instr_d = imem_rdata;
                skid_pc_d    = addr_q;
            end else begin
                ifid_valid_d = 1'b1;
                ifid_instr_d = imem_rdata;
                ifid_pc_d    = addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q         <= RESET_PC;
            addr_q       <= RESET_PC;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 64'h0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= NOP_INSTR;
            ifid_pc_q    <= 64'h0;
        end else begin
            pc_q         <= pc_d;
            addr_q       <= addr_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc_q    <= ifid_pc_d;
        end
    end

    assign imem_addr  = addr_q;
    assign ifid_valid = ifid_valid_q;
    assign ifid_instr = ifid_instr_q;
    assign ifid_pc    = ifid_pc_q;
    assign link_pc    = ifid_pc_q + 64'd4;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage. A bench-side memory answers
//               fetches with a programmable latency; words expected to reach
//               IF/ID are queued when served and popped when they appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;

    localparam logic [63:0] c_reset_pc = 64'h0;
    localparam logic [31:0] c_nop      = 32'h0;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        br_taken;
    logic        br_uncond;
    logic        br_reg;
    logic [63:0] br_reg_val;
    logic        ifid_valid;
    logic [31:0] ifid_instr;
    logic [63:0] ifid_pc;
    logic [63:0] link_pc;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          mem_lat = 0;
    int          req_age = 0;
    bit          ovr_en = 1'b0;
    logic [63:0] ovr_addr = 64'h0;
    logic [31:0] ovr_word = 32'h0;
    logic [63:0] next_pc;

    if_stage #(
        .RESET_PC  (c_reset_pc),
        .NOP_INSTR (c_nop)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_uncond  (br_uncond),
        .br_reg     (br_reg),
        .br_reg_val (br_reg_val),
        .ifid_valid (ifid_valid),
        .ifid_instr (ifid_instr),
        .ifid_pc    (ifid_pc),
        .link_pc    (link_pc)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (ovr_en && a == ovr_addr) return ovr_word;
        return {16'hC0DE, a[15:0]};
    endfunction

    // One clock of the memory model: ack once the request has waited mem_lat
    // cycles (0 = same cycle it is first seen). force_ack injects a stray ack.
    task automatic tick(input bit force_ack);
        bit give;
        give       = (imem_req && req_age >= mem_lat) || force_ack;
        imem_ack   = give;
        imem_rdata = give ? mem_word(imem_addr) : 32'hDEAD_BEEF;
        if (imem_req) req_age = give ? 0 : req_age + 1;
        else          req_age = 0;
        @(posedge clk);
        #1;
        imem_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({imem_req, ifid_valid, ifid_instr, ifid_pc, link_pc} !== {1'b0, 1'b0, c_nop, 64'h0, 64'h4}) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", {imem_req, ifid_valid, ifid_instr, ifid_pc, link_pc}, {1'b0, 1'b0, c_nop, 64'h0, 64'h4});
        end
        reset_n = 1'b1;
        tick(1'b0);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, c_reset_pc}) begin
            n_err++;
            $display("FAIL reset_first_req: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, c_reset_pc);
        end
        next_pc = c_reset_pc;
    endtask

    task automatic test_seq(input int n);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back('{pc: next_pc, instr: mem_word(next_pc)});
            tick(1'b0);
            e = exp_q.pop_front();
            n_cmp++;
            if ({ifid_valid, ifid_pc, ifid_instr, link_pc, imem_req} !== {1'b1, e.pc, e.instr, e.pc + 64'd4, 1'b0}) begin
                n_err++;
                $display("FAIL seq_ifid: got v=%b pc=%h i=%h link=%h req=%b want pc=%h i=%h", ifid_valid, ifid_pc, ifid_instr, link_pc, imem_req, e.pc, e.instr);
            end
            next_pc = next_pc + 64'd4;
            // Last idle cycle also carries a stray ack that must be ignored.
            tick(k == n - 1);
            n_cmp++;
            if ({ifid_valid, ifid_instr, imem_req, imem_addr} !== {1'b0, c_nop, 1'b1, next_pc}) begin
                n_err++;
                $display("FAIL seq_bubble: got v=%b i=%h req=%b addr=%h want v=0 i=%h req=1 addr=%h", ifid_valid, ifid_instr, imem_req, imem_addr, c_nop, next_pc);
            end
        end
    endtask

    task automatic test_branch_drop();
        logic [63:0] p;
        p        = next_pc;
        ovr_en   = 1'b1;
        ovr_addr = p;
        ovr_word = 32'h1400_0003;              // B, imm26 = 3
        exp_q.push_back('{pc: p, instr: ovr_word});
        tick(1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e.pc, e.instr}) begin
            n_err++;
            $display("FAIL b_ifid: got v=%b pc=%h i=%h want pc=%h i=%h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
        stall = 1'b1;
        tick(1'b0);
        n_cmp++;
        if ({ifid_valid, ifid_pc, imem_req, imem_addr} !== {1'b1, p, 1'b1, p + 64'd4}) begin
            n_err++;
            $display("FAIL b_hold: got v=%b pc=%h req=%b addr=%h want v=1 pc=%h req=1 addr=%h", ifid_valid, ifid_pc, imem_req, imem_addr, p, p + 64'd4);
        end
        stall     = 1'b0;
        br_taken  = 1'b1;
        br_uncond = 1'b1;
        mem_lat   = 2;
        tick(1'b0);
        br_taken  = 1'b0;
        br_uncond = 1'b0;
        n_cmp++;
        if ({ifid_valid, ifid_instr, imem_req, imem_addr} !== {1'b0, c_nop, 1'b1, p + 64'd4}) begin
            n_err++;
            $display("FAIL b_redirect: got v=%b i=%h req=%b addr=%h want v=0 i=%h req=1 addr=%h", ifid_valid, ifid_instr, imem_req, imem_addr, c_nop, p + 64'd4);
        end
        tick(1'b0);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, p + 64'd4}) begin
            n_err++;
            $display("FAIL b_drop_hold: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, p + 64'd4);
        end
        tick(1'b0);                            // late ack of dropped word
        n_cmp++;
        if ({ifid_valid, ifid_instr, imem_req} !== {1'b0, c_nop, 1'b0}) begin
            n_err++;
            $display("FAIL b_drop_data: got v=%b i=%h req=%b want v=0 i=%h req=0", ifid_valid, ifid_instr, imem_req, c_nop);
        end
        mem_lat = 0;
        tick(1'b0);
        next_pc = p + 64'd12;
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, next_pc}) begin
            n_err++;
            $display("FAIL b_target: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, next_pc);
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_stall();
        logic [63:0] a;
        a = next_pc;
        exp_q.push_back('{pc: a, instr: mem_word(a)});
        tick(1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e.pc, e.instr}) begin
            n_err++;
            $display("FAIL st_ifid: got v=%b pc=%h i=%h want pc=%h i=%h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
        stall = 1'b1;
        tick(1'b0);
        n_cmp++;
        if ({ifid_valid, ifid_pc, imem_req, imem_addr} !== {1'b1, a, 1'b1, a + 64'd4}) begin
            n_err++;
            $display("FAIL st_issue: got v=%b pc=%h req=%b addr=%h want v=1 pc=%h req=1 addr=%h", ifid_valid, ifid_pc, imem_req, imem_addr, a, a + 64'd4);
        end
        exp_q.push_back('{pc: a + 64'd4, instr: mem_word(a + 64'd4)});
        for (int c = 0; c < 2; c++) begin
            tick(1'b0);                        // first: ack into skid; second: skid full
            n_cmp++;
            if ({ifid_valid, ifid_pc, imem_req} !== {1'b1, a, 1'b0}) begin
                n_err++;
                $display("FAIL st_skid%0d: got v=%b pc=%h req=%b want v=1 pc=%h req=0", c, ifid_valid, ifid_pc, imem_req, a);
            end
        end
        stall = 1'b0;
        tick(1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_pc, ifid_instr, imem_req} !== {1'b1, e.pc, e.instr, 1'b0}) begin
            n_err++;
            $display("FAIL st_drain: got v=%b pc=%h i=%h req=%b want pc=%h i=%h req=0", ifid_valid, ifid_pc, ifid_instr, imem_req, e.pc, e.instr);
        end
        tick(1'b0);
        next_pc = a + 64'd8;
        n_cmp++;
        if ({ifid_valid, imem_req, imem_addr} !== {1'b0, 1'b1, next_pc}) begin
            n_err++;
            $display("FAIL st_resume: got v=%b req=%b addr=%h want v=0 req=1 addr=%h", ifid_valid, imem_req, imem_addr, next_pc);
        end
    endtask

    task automatic test_cbz_and_br();
        logic [63:0] p;
        p        = next_pc;
        ovr_en   = 1'b1;
        ovr_addr = p;
        ovr_word = 32'hB4FF_FFC0;              // CBZ, imm19 = 0x7FFFE (-2)
        exp_q.push_back('{pc: p, instr: ovr_word});
        tick(1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e.pc, e.instr}) begin
            n_err++;
            $display("FAIL cbz_ifid: got v=%b pc=%h i=%h want pc=%h i=%h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
        stall = 1'b1;
        tick(1'b0);
        stall    = 1'b0;
        br_taken = 1'b1;
        tick(1'b0);                            // ack coincides with redirect
        br_taken = 1'b0;
        n_cmp++;
        if ({ifid_valid, ifid_instr, imem_req} !== {1'b0, c_nop, 1'b0}) begin
            n_err++;
            $display("FAIL cbz_discard: got v=%b i=%h req=%b want v=0 i=%h req=0", ifid_valid, ifid_instr, imem_req, c_nop);
        end
        tick(1'b0);
        next_pc = p - 64'd8;
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, next_pc}) begin
            n_err++;
            $display("FAIL cbz_target: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, next_pc);
        end
        ovr_en = 1'b0;
        exp_q.push_back('{pc: next_pc, instr: mem_word(next_pc)});
        tick(1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e.pc, e.instr}) begin
            n_err++;
            $display("FAIL br_ifid: got v=%b pc=%h i=%h want pc=%h i=%h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
        br_taken   = 1'b1;
        br_reg     = 1'b1;
        br_reg_val = 64'h43;
        tick(1'b0);                            // redirect while idle
        br_taken   = 1'b0;
        br_reg     = 1'b0;
        next_pc    = 64'h40;
        n_cmp++;
        if ({ifid_valid, ifid_instr, imem_req, imem_addr} !== {1'b0, c_nop, 1'b1, next_pc}) begin
            n_err++;
            $display("FAIL br_target: got v=%b i=%h req=%b addr=%h want v=0 i=%h req=1 addr=%h", ifid_valid, ifid_instr, imem_req, imem_addr, c_nop, next_pc);
        end
    endtask

    task automatic test_ignored_branch();
        logic [63:0] a;
        a = next_pc;
        exp_q.push_back('{pc: a, instr: mem_word(a)});
        tick(1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e.pc, e.instr}) begin
            n_err++;
            $display("FAIL ign_ifid: got v=%b pc=%h i=%h want pc=%h i=%h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
        stall    = 1'b1;
        br_taken = 1'b1;
        tick(1'b0);
        stall    = 1'b0;
        br_taken = 1'b0;
        n_cmp++;
        if ({ifid_valid, ifid_pc, imem_req, imem_addr} !== {1'b1, a, 1'b1, a + 64'd4}) begin
            n_err++;
            $display("FAIL ign_stalled_br: got v=%b pc=%h req=%b addr=%h want v=1 pc=%h req=1 addr=%h", ifid_valid, ifid_pc, imem_req, imem_addr, a, a + 64'd4);
        end
        exp_q.push_back('{pc: a + 64'd4, instr: mem_word(a + 64'd4)});
        tick(1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e.pc, e.instr}) begin
            n_err++;
            $display("FAIL ign_seq: got v=%b pc=%h i=%h want pc=%h i=%h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
        tick(1'b0);
        br_taken = 1'b1;                       // IF/ID invalid: must be ignored
        mem_lat  = 1;
        tick(1'b0);
        br_taken = 1'b0;
        n_cmp++;
        if ({ifid_valid, imem_req, imem_addr} !== {1'b0, 1'b1, a + 64'd8}) begin
            n_err++;
            $display("FAIL ign_invalid_br: got v=%b req=%b addr=%h want v=0 req=1 addr=%h", ifid_valid, imem_req, imem_addr, a + 64'd8);
        end
        exp_q.push_back('{pc: a + 64'd8, instr: mem_word(a + 64'd8)});
        tick(1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e.pc, e.instr}) begin
            n_err++;
            $display("FAIL ign_kept: got v=%b pc=%h i=%h want pc=%h i=%h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
        mem_lat = 0;
        next_pc = a + 64'd12;
    endtask

    task automatic test_reset_mid();
        tick(1'b0);
        n_cmp++;
        if ({imem_req, imem_addr} !== {1'b1, next_pc}) begin
            n_err++;
            $display("FAIL rst_pre: got req=%b addr=%h want req=1 addr=%h", imem_req, imem_addr, next_pc);
        end
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({imem_req, ifid_valid, ifid_instr, ifid_pc} !== {1'b0, 1'b0, c_nop, 64'h0}) begin
            n_err++;
            $display("FAIL rst_async: got req=%b v=%b i=%h pc=%h want req=0 v=0 i=%h pc=0", imem_req, ifid_valid, ifid_instr, ifid_pc, c_nop);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        repeat (2) @(posedge clk);
        #1;
        imem_ack = 1'b0;
        reset_n  = 1'b1;
        req_age  = 0;
        tick(1'b0);
        n_cmp++;
        if ({imem_req, imem_addr, ifid_valid} !== {1'b1, c_reset_pc, 1'b0}) begin
            n_err++;
            $display("FAIL rst_restart: got req=%b addr=%h v=%b want req=1 addr=%h v=0", imem_req, imem_addr, ifid_valid, c_reset_pc);
        end
        exp_q.push_back('{pc: c_reset_pc, instr: mem_word(c_reset_pc)});
        tick(1'b0);
        e = exp_q.pop_front();
        n_cmp++;
        if ({ifid_valid, ifid_pc, ifid_instr} !== {1'b1, e.pc, e.instr}) begin
            n_err++;
            $display("FAIL rst_first_word: got v=%b pc=%h i=%h want pc=%h i=%h", ifid_valid, ifid_pc, ifid_instr, e.pc, e.instr);
        end
        n_cmp++;
        if (exp_q.size() !== 0) begin
            n_err++;
            $display("FAIL sb_empty: got %0d entries left want 0", exp_q.size());
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        imem_ack   = 1'b0;
        imem_rdata = 32'h0;
        stall      = 1'b0;
        br_taken   = 1'b0;
        br_uncond  = 1'b0;
        br_reg     = 1'b0;
        br_reg_val = 64'h0;
        next_pc    = c_reset_pc;
        test_reset();
        test_seq(4);
        test_branch_drop();
        test_stall();
        test_cbz_and_br();
        test_ignored_branch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have parameters: RESET_PC, 64'h0, first fetch address; NOP_INSTR, 32'h0, bubble encoding (decodes to no-op in cpu_ctrl).
REQ-002 SHALL have ports: clk input 1 clock; reset_n input 1 asynchronous active-low reset; all state on rising clk.
REQ-003 imem_req output 1 fetch request; imem_addr output 64 fetch address; imem_ack input 1 response valid, data on imem_rdata input 32.
REQ-004 stall input 1 hold IF/ID (hazard unit); br_taken input 1 (BrTaken); br_uncond input 1 (UncondBr); br_reg input 1 (BRBranch); br_reg_val input 64 BR target register value.
REQ-005 ifid_valid output 1; ifid_instr output 32 to cpu_ctrl; ifid_pc output 64; link_pc output 64 (ifid_pc+4, for BL).

Function
REQ-006 SHALL keep exactly one outstanding imem request; imem_req and imem_addr held stable from assertion until the imem_ack cycle; imem_ack outside an outstanding request ignored.
REQ-007 FSM states: IDLE (no request), WAIT (request outstanding), DROP (outstanding request whose data is discarded).
REQ-008 IDLE -> WAIT when skid buffer empty; imem_addr = pc.
REQ-009 WAIT with imem_ack, no redirect: fetched word to IF/ID if IF/ID empty or not stall, else to one-entry skid buffer; pc <= pc+4; next state IDLE (new request issued following cycle).
REQ-010 Skid buffer full: no new request; on first cycle with stall low, skid contents move to IF/ID, buffer empties.
REQ-011 Stall high: IF/ID holds valid, instr, pc unchanged.
REQ-012 Redirect = br_taken & ifid_valid & !stall; br_taken while stall high or ifid_valid low SHALL be ignored.
REQ-013 Target: br_reg -> {br_reg_val[63:2],2'b00}; else br_uncond -> ifid_pc + (sext(ifid_instr[25:0])<<2); else ifid_pc + (sext(ifid_instr[23:5])<<2); arithmetic modulo 2^64.
REQ-014 On redirect: pc <= target; next cycle ifid_valid=0, ifid_instr=NOP_INSTR; skid buffer cleared.
REQ-015 Redirect in WAIT without imem_ack -> DROP; DROP holds old request until imem_ack, discards data, -> IDLE.
REQ-016 Redirect coincident with imem_ack: data discarded, pc not incremented, -> IDLE.
REQ-017 Redirect in IDLE: next request uses target.
REQ-018 Invalid IF/ID SHALL always present ifid_instr=NOP_INSTR; link_pc = ifid_pc+4 modulo 2^64.
REQ-019 Fetch-to-IF/ID latency: one cycle after imem_ack (registered).

Reset
REQ-020 reset_n low asynchronously: state IDLE, pc=RESET_PC, skid empty, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, imem_req=0.
REQ-021 Reset mid-request: outstanding request abandoned; imem_ack during reset ignored; first request after release uses RESET_PC, issued first rising edge with reset_n high.

Verification
REQ-022 Zero-wait memory (ack cycle after req), no stall: IF/ID shows pc 0,4,8,... every 2 cycles; instr matches memory.
REQ-023 Stall held 3 cycles while ack arrives for pc 8: IF/ID holds pc 4; pc 8 word enters skid; no further req until stall drops; then IF/ID=pc 8.
REQ-024 B at pc 0x10, imm26=3, redirect while request for 0x14 outstanding (ack 2 cycles later): 0x14 data dropped, next imem_addr=0x1C, IF/ID bubble=32'h0.
REQ-025 CBZ at pc 0x20, imm19=-2 (7FFFE), br_taken coincident with ack: data discarded, next imem_addr=0x18; BR with br_reg_val=0x43 -> next imem_addr=0x40.
REQ-026 br_taken=1 with stall=1: no redirect, pc sequential; reset_n pulsed low mid-WAIT: outputs reset immediately, next imem_addr=RESET_PC.
